// File: rtl/hasti_pkg.sv
// Shared AHB-Lite encodings and helpers used by the HASTI slaves.
package hasti_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Two-cycle ERROR response sequencing.
  typedef enum logic [1:0] {
    ST_OK,
    ST_ERR1,
    ST_ERR2
  } hasti_err_state_t;

  // A transfer is legal when its size is supported and naturally aligned.
  function automatic logic xferLegal(input logic [2:0] size, input logic [1:0] a);
    logic ok;
    case (size)
      HSIZE_BYTE: ok = 1'b1;
      HSIZE_HALF: ok = ~a[0];
      HSIZE_WORD: ok = (a == 2'b00);
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Byte lanes touched by a legal transfer.
  function automatic logic [3:0] byteEnables(input logic [2:0] size, input logic [1:0] a);
    logic [3:0] be;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << a;
      HSIZE_HALF: be = 4'b0011 << a;
      default:    be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/hasti_sram_wbuf.sv
// One-entry parked-write buffer plus the byte merge applied to reads that hit it.
module hasti_sram_wbuf
  import hasti_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          load_i,
  input  logic          drain_i,
  input  logic [AW-1:0] ldIdx_i,
  input  logic [3:0]    ldBe_i,
  input  logic [31:0]   ldData_i,
  input  logic [AW-1:0] rdIdx_i,
  input  logic [31:0]   rdRaw_i,
  output logic          wbValid_o,
  output logic [AW-1:0] wbIdx_o,
  output logic [3:0]    wbBe_o,
  output logic [31:0]   wbData_o,
  output logic [31:0]   merged_o
);

  logic          wbValid_q;
  logic [AW-1:0] wbIdx_q;
  logic [3:0]    wbBe_q;
  logic [31:0]   wbData_q;
  logic          hit;

  // Buffer register: a load always wins; loads and drains never coincide because a drain needs a cycle with no write data phase.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wbValid_q <= 1'b0;
      wbIdx_q   <= '0;
      wbBe_q    <= '0;
      wbData_q  <= '0;
    end else if (load_i) begin
      wbValid_q <= 1'b1;
      wbIdx_q   <= ldIdx_i;
      wbBe_q    <= ldBe_i;
      wbData_q  <= ldData_i;
    end else if (drain_i) begin
      wbValid_q <= 1'b0;
    end
  end

  assign hit = wbValid_q && (wbIdx_q == rdIdx_i);

  // Overlay the registered buffered bytes on the SRAM word so a read never sees stale data.
  always_comb begin
    merged_o = rdRaw_i;
    for (int b = 0; b < 4; b++) begin
      if (hit && wbBe_q[b]) begin
        merged_o[8*b +: 8] = wbData_q[8*b +: 8];
      end
    end
  end

  assign wbValid_o = wbValid_q;
  assign wbIdx_o   = wbIdx_q;
  assign wbBe_o    = wbBe_q;
  assign wbData_o  = wbData_q;

endmodule

// File: rtl/hasti_sram_slave.sv
// AHB-Lite slave fronting a single-port synchronous SRAM with zero-wait reads and writes.
module hasti_sram_slave
  import hasti_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic          hclk,
  input  logic          hresetn,
  input  logic [31:0]   haddr,
  input  logic          hwrite,
  input  logic [2:0]    hsize,
  input  logic [2:0]    hburst,
  input  logic [3:0]    hprot,
  input  logic          hmastlock,
  input  logic [1:0]    htrans,
  input  logic [31:0]   hwdata,
  output logic [31:0]   hrdata,
  output logic          hready,
  output logic          hresp,
  output logic          sram_en,
  output logic          sram_we,
  output logic [3:0]    sram_be,
  output logic [AW-1:0] sram_addr,
  output logic [31:0]   sram_wdata,
  input  logic [31:0]   sram_rdata
);

  hasti_err_state_t state_q, state_d;
  logic          rdPhase_q, rdPhase_d;
  logic          wrPhase_q, wrPhase_d;
  logic [AW-1:0] rdIdx_q, rdIdx_d;
  logic [AW-1:0] wrIdx_q, wrIdx_d;
  logic [3:0]    wrBe_q, wrBe_d;

  logic          active, accept, legal;
  logic          rdAddrPhase, wrAddrPhase;
  logic          wrDirect, wbLoad, wbDrain;
  logic [AW-1:0] addrIdx;
  logic [3:0]    addrBe;
  logic          wbValid;
  logic [AW-1:0] wbIdx;
  logic [3:0]    wbBe;
  logic [31:0]   wbData;
  logic [31:0]   merged;
  logic          unusedOk;

  assign unusedOk = ^{hburst, hprot, hmastlock, haddr[31:AW+2]};

  // Address-phase decode; everything is gated by reset so the SRAM stays idle while hresetn is low.
  always_comb begin
    active = 1'b0;
    case (htrans)
      HTRANS_NONSEQ, HTRANS_SEQ: active = 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  active = 1'b0;
    endcase
    hready      = !hresetn || (state_q != ST_ERR1);
    hresp       = (hresetn && (state_q != ST_OK)) ? HRESP_ERROR : HRESP_OKAY;
    accept      = hresetn && hready && active;
    legal       = xferLegal(hsize, haddr[1:0]);
    addrIdx     = haddr[AW+1:2];
    addrBe      = byteEnables(hsize, haddr[1:0]);
    rdAddrPhase = accept && legal && !hwrite;
    wrAddrPhase = accept && legal && hwrite;
    wrDirect    = hresetn && wrPhase_q && !rdAddrPhase;
    wbLoad      = hresetn && wrPhase_q && rdAddrPhase;
    wbDrain     = hresetn && wbValid && !rdAddrPhase && !wrPhase_q;
  end

  // SRAM port arbitration: read address phase, then direct write, then buffer drain.
  always_comb begin
    sram_en    = 1'b0;
    sram_we    = 1'b0;
    sram_be    = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (rdAddrPhase) begin
      sram_en   = 1'b1;
      sram_be   = addrBe;
      sram_addr = addrIdx;
    end else if (wrDirect) begin
      sram_en    = 1'b1;
      sram_we    = 1'b1;
      sram_be    = wrBe_q;
      sram_addr  = wrIdx_q;
      sram_wdata = hwdata;
    end else if (wbDrain) begin
      sram_en    = 1'b1;
      sram_we    = 1'b1;
      sram_be    = wbBe;
      sram_addr  = wbIdx;
      sram_wdata = wbData;
    end
  end

  // Error FSM and data-phase bookkeeping for the next cycle.
  always_comb begin
    state_d   = state_q;
    rdPhase_d = rdAddrPhase;
    wrPhase_d = wrAddrPhase;
    rdIdx_d   = rdAddrPhase ? addrIdx : rdIdx_q;
    wrIdx_d   = wrAddrPhase ? addrIdx : wrIdx_q;
    wrBe_d    = wrAddrPhase ? addrBe : wrBe_q;
    case (state_q)
      ST_OK, ST_ERR2: state_d = (accept && !legal) ? ST_ERR1 : ST_OK;
      ST_ERR1:        state_d = ST_ERR2;
      default:        state_d = ST_OK;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state_q   <= ST_OK;
      rdPhase_q <= 1'b0;
      wrPhase_q <= 1'b0;
      rdIdx_q   <= '0;
      wrIdx_q   <= '0;
      wrBe_q    <= '0;
    end else begin
      state_q   <= state_d;
      rdPhase_q <= rdPhase_d;
      wrPhase_q <= wrPhase_d;
      rdIdx_q   <= rdIdx_d;
      wrIdx_q   <= wrIdx_d;
      wrBe_q    <= wrBe_d;
    end
  end

  hasti_sram_wbuf #(.AW(AW)) u_wbuf (
    .clk_i     (hclk),
    .rstn_i    (hresetn),
    .load_i    (wbLoad),
    .drain_i   (wbDrain),
    .ldIdx_i   (wrIdx_q),
    .ldBe_i    (wrBe_q),
    .ldData_i  (hwdata),
    .rdIdx_i   (rdIdx_q),
    .rdRaw_i   (sram_rdata),
    .wbValid_o (wbValid),
    .wbIdx_o   (wbIdx),
    .wbBe_o    (wbBe),
    .wbData_o  (wbData),
    .merged_o  (merged)
  );

  assign hrdata = (hresetn && rdPhase_q) ? merged : 32'h0;

endmodule

// File: tb/tb_hasti_sram_slave.sv
// Scoreboard bench for hasti_sram_slave with a behavioural SRAM model.
module tb_hasti_sram_slave;
  import hasti_pkg::*;

  localparam int AW = 12;

  localparam int F_HRDATA = 0;
  localparam int F_HREADY = 1;
  localparam int F_HRESP  = 2;
  localparam int F_EN     = 3;
  localparam int F_WE     = 4;
  localparam int F_BE     = 5;
  localparam int F_ADDR   = 6;

  typedef struct {
    int          cyc;
    int          field;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic          hclk = 1'b0;
  logic          hresetn = 1'b0;
  logic [31:0]   haddr = '0;
  logic          hwrite = 1'b0;
  logic [2:0]    hsize = '0;
  logic [2:0]    hburst = '0;
  logic [3:0]    hprot = '0;
  logic          hmastlock = 1'b0;
  logic [1:0]    htrans = HTRANS_IDLE;
  logic [31:0]   hwdata = '0;
  logic [31:0]   hrdata;
  logic          hready;
  logic          hresp;
  logic          sram_en;
  logic          sram_we;
  logic [3:0]    sram_be;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata = '0;

  logic [31:0] mem [0:(1<<AW)-1];
  exp_t        sbQ[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  hasti_sram_slave #(.AW(AW)) dut (
    .hclk       (hclk),
    .hresetn    (hresetn),
    .haddr      (haddr),
    .hwrite     (hwrite),
    .hsize      (hsize),
    .hburst     (hburst),
    .hprot      (hprot),
    .hmastlock  (hmastlock),
    .htrans     (htrans),
    .hwdata     (hwdata),
    .hrdata     (hrdata),
    .hready     (hready),
    .hresp      (hresp),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_be    (sram_be),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  always #5 hclk = ~hclk;

  // Cycle counter, advanced at every active edge.
  always @(posedge hclk) cyc <= cyc + 1;

  // Behavioural synchronous SRAM: byte-enabled writes, one-cycle read latency.
  always @(posedge hclk) begin
    if (sram_en) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++) begin
          if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
        end
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  initial begin
    for (int i = 0; i < (1<<AW); i++) mem[i] = 32'h0;
  end

  // Drive one cycle of bus inputs just after the active edge.
  task automatic applyStimulus(input logic rstn, input logic [1:0] trans, input logic wr,
                               input logic [2:0] size, input logic [31:0] addr,
                               input logic [31:0] wdata);
    @(posedge hclk);
    #1;
    hresetn = rstn;
    htrans  = trans;
    hwrite  = wr;
    hsize   = size;
    haddr   = addr;
    hwdata  = wdata;
  endtask

  task automatic idle(input logic [31:0] wdata);
    applyStimulus(1'b1, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0, wdata);
  endtask

  // Queue an expectation for the outputs of the cycle currently being driven.
  task automatic pushExpect(input int field, input logic [31:0] val, input string name);
    exp_t e;
    e.cyc   = cyc;
    e.field = field;
    e.val   = val;
    e.name  = name;
    sbQ.push_back(e);
  endtask

  // Compare one scoreboard entry against the sampled DUT outputs.
  task automatic checkOutput(input exp_t e);
    logic [31:0] act;
    case (e.field)
      F_HRDATA: act = hrdata;
      F_HREADY: act = {31'h0, hready};
      F_HRESP:  act = {31'h0, hresp};
      F_EN:     act = {31'h0, sram_en};
      F_WE:     act = {31'h0, sram_we};
      F_BE:     act = {28'h0, sram_be};
      default:  act = {{(32-AW){1'b0}}, sram_addr};
    endcase
    checks++;
    if (e.cyc != cyc) begin
      errors++;
      $display("[TB] FAIL %s: expectation for cycle %0d checked at cycle %0d", e.name, e.cyc, cyc);
    end else if (act !== e.val) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", e.name, act, e.val, cyc);
    end
  endtask

  // Monitor: consume every expectation due by this cycle, and watch the buffer-overflow invariant.
  always @(negedge hclk) begin
    while (sbQ.size() > 0 && sbQ[0].cyc <= cyc) begin
      checkOutput(sbQ.pop_front());
    end
    if (dut.wbValid && dut.wbLoad) begin
      errors++;
      $display("[TB] FAIL wbuf_overflow: load while buffer valid at cycle %0d", cyc);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // 1. reset with IDLE, then BUSY after release
    applyStimulus(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0, 32'h0);
    applyStimulus(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0, 32'h0);
    pushExpect(F_HREADY, 32'h1, "rst_hready");
    pushExpect(F_HRESP,  32'h0, "rst_hresp");
    pushExpect(F_EN,     32'h0, "rst_sram_en");
    pushExpect(F_HRDATA, 32'h0, "rst_hrdata");
    idle(32'h0);
    pushExpect(F_HREADY, 32'h1, "post_rst_hready");
    pushExpect(F_EN,     32'h0, "post_rst_sram_en");
    applyStimulus(1'b1, HTRANS_BUSY, 1'b0, HSIZE_WORD, 32'h10, 32'h0);
    pushExpect(F_HREADY, 32'h1, "busy_hready");
    pushExpect(F_EN,     32'h0, "busy_sram_en");

    // 2. word write 0x10, then read it back
    applyStimulus(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h10, 32'h0);
    pushExpect(F_EN, 32'h0, "w10_addr_en");
    idle(32'hDEADBEEF);
    pushExpect(F_EN,   32'h1, "w10_data_en");
    pushExpect(F_WE,   32'h1, "w10_data_we");
    pushExpect(F_ADDR, 32'h4, "w10_data_addr");
    pushExpect(F_BE,   32'hF, "w10_data_be");
    applyStimulus(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10, 32'h0);
    pushExpect(F_EN,   32'h1, "r10_addr_en");
    pushExpect(F_WE,   32'h0, "r10_addr_we");
    pushExpect(F_ADDR, 32'h4, "r10_addr_addr");
    idle(32'h0);
    pushExpect(F_HRDATA, 32'hDEADBEEF, "r10_hrdata");
    idle(32'h0);
    pushExpect(F_HRDATA, 32'h0, "idle_hrdata");

    // 3. prefill 0x20, byte write 0x22 collides with read 0x20
    applyStimulus(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h20, 32'h0);
    idle(32'h11223344);
    applyStimulus(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 32'h22, 32'h0);
    applyStimulus(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h20, 32'h00AA0000);
    pushExpect(F_EN,   32'h1, "haz_read_en");
    pushExpect(F_WE,   32'h0, "haz_read_we");
    pushExpect(F_ADDR, 32'h8, "haz_read_addr");
    idle(32'h0);
    pushExpect(F_HRDATA, 32'h11AA3344, "haz_merge_hrdata");
    pushExpect(F_EN,     32'h1, "drain_en");
    pushExpect(F_WE,     32'h1, "drain_we");
    pushExpect(F_BE,     32'h4, "drain_be");
    pushExpect(F_ADDR,   32'h8, "drain_addr");
    idle(32'h0);
    pushExpect(F_EN, 32'h0, "post_drain_en");
    applyStimulus(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h20, 32'h0);
    idle(32'h0);
    pushExpect(F_HRDATA, 32'h11AA3344, "drained_hrdata");

    // 4. unsupported size -> two-cycle ERROR
    applyStimulus(1'b1, HTRANS_NONSEQ, 1'b0, 3'd3, 32'h40, 32'h0);
    pushExpect(F_HREADY, 32'h1, "sz3_addr_hready");
    pushExpect(F_EN,     32'h0, "sz3_addr_en");
    idle(32'h0);
    pushExpect(F_HREADY, 32'h0, "sz3_err1_hready");
    pushExpect(F_HRESP,  32'h1, "sz3_err1_hresp");
    pushExpect(F_EN,     32'h0, "sz3_err1_en");
    idle(32'h0);
    pushExpect(F_HREADY, 32'h1, "sz3_err2_hready");
    pushExpect(F_HRESP,  32'h1, "sz3_err2_hresp");
    pushExpect(F_EN,     32'h0, "sz3_err2_en");
    idle(32'h0);
    pushExpect(F_HRESP,  32'h0, "sz3_ok_hresp");

    // 5. misaligned half, then legal word write accepted in ERR2
    applyStimulus(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_HALF, 32'h31, 32'h0);
    pushExpect(F_EN, 32'h0, "h31_addr_en");
    idle(32'h0);
    pushExpect(F_HREADY, 32'h0, "h31_err1_hready");
    pushExpect(F_HRESP,  32'h1, "h31_err1_hresp");
    applyStimulus(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h34, 32'h0);
    pushExpect(F_HREADY, 32'h1, "h31_err2_hready");
    pushExpect(F_HRESP,  32'h1, "h31_err2_hresp");
    pushExpect(F_EN,     32'h0, "w34_addr_en");
    idle(32'hCAFEF00D);
    pushExpect(F_HREADY, 32'h1, "w34_data_hready");
    pushExpect(F_HRESP,  32'h0, "w34_data_hresp");
    pushExpect(F_EN,     32'h1, "w34_data_en");
    pushExpect(F_WE,     32'h1, "w34_data_we");
    pushExpect(F_ADDR,   32'hD, "w34_data_addr");
    applyStimulus(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h34, 32'h0);
    idle(32'h0);
    pushExpect(F_HRDATA, 32'hCAFEF00D, "r34_hrdata");

    // 6. repeat the hazard setup, reset during the read data phase
    applyStimulus(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h20, 32'h0);
    idle(32'h11223344);
    applyStimulus(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 32'h22, 32'h0);
    applyStimulus(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h20, 32'h00AA0000);
    applyStimulus(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0, 32'h0);
    pushExpect(F_HRDATA, 32'h0, "rstmid_hrdata");
    pushExpect(F_EN,     32'h0, "rstmid_en");
    pushExpect(F_HREADY, 32'h1, "rstmid_hready");
    pushExpect(F_HRESP,  32'h0, "rstmid_hresp");
    idle(32'h0);
    pushExpect(F_EN, 32'h0, "rstrel_no_drain");
    idle(32'h0);
    pushExpect(F_EN, 32'h0, "rstrel_no_drain2");
    applyStimulus(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h20, 32'h0);
    idle(32'h0);
    pushExpect(F_HRDATA, 32'h11223344, "rstrel_hrdata");

    // Let the monitor drain the scoreboard, bounded.
    for (int i = 0; i < 10 && sbQ.size() > 0; i++) @(posedge hclk);
    while (sbQ.size() > 0) begin
      exp_t e;
      e = sbQ.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL %s: never checked (cycle %0d)", e.name, e.cyc);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
